// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - borrow_in over WIDTH/DIGIT cycles, LSB digit first,
// behind a start/busy/done handshake with borrow, signed-overflow and zero flags.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_borrow_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out,
    output logic             o_overflow,
    output logic             o_zero
);
    localparam int DIG_SAFE = (DIGIT >= 1) ? DIGIT : 1;
    localparam int N        = WIDTH / DIG_SAFE;
    localparam int CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (DIGIT < 1 || (WIDTH % DIG_SAFE) != 0 || WIDTH < 1) begin : g_bad_param
            $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_busy;
    logic            w_done;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_overflow;
    logic             r_zero;

    logic [DIGIT-1:0] w_d;
    logic [DIGIT:0]   w_bc;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One digit of full subtractors, each made of two half subtractors.
    assign w_bc[0] = r_borrow;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fs
            logic w_hd;
            logic w_hb1;
            logic w_hb2;
            assign w_hd         = r_a[gi] ^ r_b[gi];
            assign w_hb1        = ~r_a[gi] & r_b[gi];
            assign w_d[gi]      = w_hd ^ w_bc[gi];
            assign w_hb2        = ~w_hd & w_bc[gi];
            assign w_bc[gi + 1] = w_hb1 | w_hb2;
        end
    endgenerate

    // The minuend register doubles as the result accumulator: each step shifts the
    // consumed digit out at the bottom and the new difference digit in at the top.
    generate
        if (N == 1) begin : g_single
            assign w_a_next = w_d;
            assign w_b_next = r_b;
        end else begin : g_multi
            assign w_a_next = {w_d, r_a[WIDTH-1:DIGIT]};
            assign w_b_next = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
        end else if (w_accept) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_a_msb  <= i_a[WIDTH-1];
            r_b_msb  <= i_b[WIDTH-1];
            r_borrow <= i_borrow_in;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_borrow <= w_bc[DIGIT];
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_diff       <= w_a_next;
                r_borrow_out <= w_bc[DIGIT];
                r_overflow   <= (r_a_msb ^ r_b_msb) & (w_a_next[WIDTH-1] ^ r_a_msb);
                r_zero       <= (w_a_next == '0);
            end
        end
    end

    assign o_busy       = w_busy;
    assign o_done       = w_done;
    assign o_diff       = r_diff;
    assign o_borrow_out = r_borrow_out;
    assign o_overflow   = r_overflow;
    assign o_zero       = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three configurations (DIGIT 4, 1, 16) share one stimulus stream
// and are compared every cycle against an arithmetic model with a cycle-countdown timing view.
module tb_serial_subtractor;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        bin_in;

    logic [2:0]       busy_w;
    logic [2:0]       done_w;
    logic [2:0][15:0] diff_w;
    logic [2:0]       bo_w;
    logic [2:0]       ov_w;
    logic [2:0]       z_w;

    int n_vec  = 0;
    int n_fail = 0;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int DG = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);
            serial_subtractor #(.WIDTH(16), .DIGIT(DG)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .i_start     (start),
                .i_a         (a_in),
                .i_b         (b_in),
                .i_borrow_in (bin_in),
                .o_busy      (busy_w[gi]),
                .o_done      (done_w[gi]),
                .o_diff      (diff_w[gi]),
                .o_borrow_out(bo_w[gi]),
                .o_overflow  (ov_w[gi]),
                .o_zero      (z_w[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nsteps(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 16 : 1);
    endfunction

    // Model: remaining busy cycles per instance plus the arithmetic result of the accepted operands.
    int          m_rem  [3];
    logic        m_done [3];
    logic [15:0] m_diff [3];
    logic        m_bo   [3];
    logic        m_ov   [3];
    logic        m_z    [3];
    logic [15:0] p_diff [3];
    logic        p_bo   [3];
    logic        p_ov   [3];
    logic        p_z    [3];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            int ud;
            int sd;
            if (rst) begin
                m_rem[i]  <= 0;
                m_done[i] <= 1'b0;
                m_diff[i] <= '0;
                m_bo[i]   <= 1'b0;
                m_ov[i]   <= 1'b0;
                m_z[i]    <= 1'b0;
            end else if (m_rem[i] == 1) begin
                m_rem[i]  <= 0;
                m_done[i] <= 1'b1;
                m_diff[i] <= p_diff[i];
                m_bo[i]   <= p_bo[i];
                m_ov[i]   <= p_ov[i];
                m_z[i]    <= p_z[i];
            end else if (m_rem[i] > 1) begin
                m_rem[i]  <= m_rem[i] - 1;
                m_done[i] <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (start) begin
                    ud = int'(a_in) - int'(b_in) - int'(bin_in);
                    sd = int'($signed(a_in)) - int'($signed(b_in)) - int'(bin_in);
                    p_diff[i] <= ud[15:0];
                    p_bo[i]   <= (ud < 0);
                    p_ov[i]   <= (sd > 32767) || (sd < -32768);
                    p_z[i]    <= (ud[15:0] == 16'h0000);
                    m_rem[i]  <= nsteps(i);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.busy", i), 32'(busy_w[i]), 32'(m_rem[i] > 0));
            chk($sformatf("u%0d.done", i), 32'(done_w[i]), 32'(m_done[i]));
            chk($sformatf("u%0d.diff", i), 32'(diff_w[i]), 32'(m_diff[i]));
            chk($sformatf("u%0d.borrow_out", i), 32'(bo_w[i]), 32'(m_bo[i]));
            chk($sformatf("u%0d.overflow", i), 32'(ov_w[i]), 32'(m_ov[i]));
            chk($sformatf("u%0d.zero", i), 32'(z_w[i]), 32'(m_z[i]));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    // Launch one operation on all instances; operands are scrambled after the start edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          output int bcnt, output int dat);
        a_in   = a;
        b_in   = b;
        bin_in = bi;
        start  = 1'b1;
        bcnt   = 0;
        dat    = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 1) begin
                start  = 1'b0;
                a_in   = 16'($urandom);
                b_in   = 16'($urandom);
                bin_in = 1'($urandom);
            end
            if (busy_w[0]) bcnt++;
            if (done_w[0] && dat == 0) dat = t;
            if (dat != 0 && busy_w == 3'b000 && done_w == 3'b000) break;
        end
        if (dat == 0) chk("run_op.done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (busy_w == 3'b000 && done_w == 3'b000) begin
                ok = 1;
                break;
            end
        end
        chk("wait_idle", 32'(ok), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int bc;
        int dt;
        int cnt;
        int seen;
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        bin_in = 1'b0;
        tick();
        chk("reset.busy", 32'(busy_w), 32'd0);
        chk("reset.done", 32'(done_w), 32'd0);
        chk("reset.diff0", 32'(diff_w[0]), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        run_op(16'h1234, 16'h0234, 1'b0, bc, dt);
        $display("op 1234-0234-0: diff=%h busy_cycles=%0d done_tick=%0d", diff_w[0], bc, dt);
        chk("t1.diff", 32'(diff_w[0]), 32'h1000);
        chk("t1.model_diff", 32'(m_diff[0]), 32'h1000);
        chk("t1.flags", {29'd0, bo_w[0], ov_w[0], z_w[0]}, 32'd0);
        chk("t1.busy_cycles", 32'(bc), 32'd4);
        chk("t1.done_tick", 32'(dt), 32'd5);

        run_op(16'h0000, 16'h0001, 1'b0, bc, dt);
        $display("op 0000-0001-0: diff=%h bo=%b ov=%b", diff_w[0], bo_w[0], ov_w[0]);
        chk("t2a.diff", 32'(diff_w[0]), 32'hFFFF);
        chk("t2a.borrow_out", 32'(bo_w[0]), 32'd1);
        chk("t2a.overflow", 32'(ov_w[0]), 32'd0);

        run_op(16'h8000, 16'h0001, 1'b0, bc, dt);
        $display("op 8000-0001-0: diff=%h bo=%b ov=%b", diff_w[0], bo_w[0], ov_w[0]);
        chk("t2b.diff", 32'(diff_w[0]), 32'h7FFF);
        chk("t2b.borrow_out", 32'(bo_w[0]), 32'd0);
        chk("t2b.overflow", 32'(ov_w[0]), 32'd1);
        chk("t2b.model_overflow", 32'(m_ov[0]), 32'd1);

        run_op(16'h0005, 16'h0004, 1'b1, bc, dt);
        $display("op 0005-0004-1: diff=%h bo=%b z=%b", diff_w[0], bo_w[0], z_w[0]);
        chk("t3a.diff", 32'(diff_w[0]), 32'h0000);
        chk("t3a.zero", 32'(z_w[0]), 32'd1);
        chk("t3a.borrow_out", 32'(bo_w[0]), 32'd0);

        run_op(16'h0000, 16'hFFFF, 1'b1, bc, dt);
        $display("op 0000-FFFF-1: diff=%h bo=%b z=%b", diff_w[0], bo_w[0], z_w[0]);
        chk("t3b.diff", 32'(diff_w[0]), 32'h0000);
        chk("t3b.borrow_out", 32'(bo_w[0]), 32'd1);
        chk("t3b.zero", 32'(z_w[0]), 32'd1);
        chk("t3b.model_borrow", 32'(m_bo[0]), 32'd1);

        // Start while busy is ignored, then a back-to-back start in the done cycle.
        a_in = 16'h1234; b_in = 16'h0234; bin_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a_in = 16'hFFFF; b_in = 16'h0001; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            if (done_w[0]) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk("t4.first_done_seen", 32'(seen), 32'd1);
        $display("op 1234-0234 with ignored start: diff=%h", diff_w[0]);
        chk("t4.ignored_start_diff", 32'(diff_w[0]), 32'h1000);
        a_in = 16'h0003; b_in = 16'h0005; bin_in = 1'b0; start = 1'b1;
        dt = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 1) start = 1'b0;
            if (done_w[0]) begin
                dt = t;
                break;
            end
        end
        $display("op 0003-0005-0 back-to-back: diff=%h bo=%b done_tick=%0d", diff_w[0], bo_w[0], dt);
        chk("t4.b2b_done_tick", 32'(dt), 32'd5);
        chk("t4.b2b_diff", 32'(diff_w[0]), 32'hFFFE);
        chk("t4.b2b_borrow_out", 32'(bo_w[0]), 32'd1);
        wait_idle();

        // Reset two cycles into an operation.
        a_in = 16'h4321; b_in = 16'h1111; bin_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        $display("reset mid-op: busy=%b done=%b diff0=%h", busy_w, done_w, diff_w[0]);
        chk("t5.busy", 32'(busy_w), 32'd0);
        chk("t5.done", 32'(done_w), 32'd0);
        chk("t5.diff0", 32'(diff_w[0]), 32'd0);
        chk("t5.flags0", {29'd0, bo_w[0], ov_w[0], z_w[0]}, 32'd0);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (done_w[0]) cnt++;
        end
        chk("t5.no_done_after_abort", 32'(cnt), 32'd0);
        run_op(16'h1234, 16'h0234, 1'b0, bc, dt);
        $display("op after reset 1234-0234-0: diff=%h", diff_w[0]);
        chk("t5.restart_diff", 32'(diff_w[0]), 32'h1000);

        for (int v = 0; v < 1000; v++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rbi;
            ra  = 16'($urandom);
            rb  = (v % 7 == 0) ? ra : 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            run_op(ra, rb, rbi, bc, dt);
            $display("rand %0d: %h-%h-%b diff=%h/%h/%h bo=%b ov=%b z=%b", v, ra, rb, rbi,
                     diff_w[0], diff_w[1], diff_w[2], bo_w[0], ov_w[0], z_w[0]);
            chk("rand.busy_cycles", 32'(bc), 32'd4);
            chk("rand.done_tick", 32'(dt), 32'd5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised digit-serial subtractor computing A - B - borrow_in over WIDTH/DIGIT clock cycles, LSB digit first, with the inter-digit borrow carried in a register. Each digit step is a DIGIT-bit ripple of full-subtractor cells built from the team's half-subtractor equations (diff = x^y, borrow = ~x&y). It is a low-area arithmetic unit behind a start/done handshake. It adds unsigned borrow-out, signed overflow and zero flags.

Parameters:
WIDTH, 16, operand and result width in bits; must be >= 1.
DIGIT, 4, bits processed per cycle; must be >= 1 and divide WIDTH exactly. N = WIDTH/DIGIT is the step count.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when not busy
a  input  WIDTH  minuend; sampled on the accepted start edge
b  input  WIDTH  subtrahend; sampled on the accepted start edge
borrow_in  input  1  initial borrow into the LSB; sampled on the accepted start edge
busy  output  1  high while a subtraction is in progress
done  output  1  single-cycle pulse; results are valid from this cycle onward
diff  output  WIDTH  result, (a - b - borrow_in) mod 2^WIDTH
borrow_out  output  1  borrow out of the MSB; 1 iff a < b + borrow_in (unsigned)
overflow  output  1  two's-complement overflow of a - b - borrow_in
zero  output  1  1 iff diff == 0

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - busy, done, diff, borrow_out, overflow and zero all go to 0.
  - The operand registers, step counter and internal borrow are cleared.
  - No done pulse is issued for an aborted operation.
- States:
  - IDLE: start=1 -> RUN. On that edge, latch a, b and borrow_in; set counter=0 and busy=1.
  - RUN: each edge processes digit[counter], bits [DIGIT*counter +: DIGIT].
    - The digit's difference is shifted into the result register and its borrow goes to the borrow register.
    - counter increments each edge.
    - On the edge that processes digit N-1, go to DONE.
  - DONE: lasts exactly one cycle with done=1 and busy=0.
    - Next state is IDLE, or RUN if start=1 in this cycle. Back-to-back operation is supported: the new operands are latched on that edge.
- Latency:
  - Accepted start at edge k; busy=1 during cycles k+1 .. k+N.
  - done=1 in the cycle after edge k+N.
  - For N=1 (DIGIT=WIDTH), done appears one cycle after the start edge.
- start while busy=1 is ignored; in-flight operands are unaffected.
- Result registers:
  - diff, borrow_out, overflow and zero update only on the completion edge (k+N).
  - They hold their values until the next completion edge or reset; they never show partial results.
- Flags:
  - borrow_out = final borrow register value.
  - overflow = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched operands.
  - zero = (diff == 0).
- Input changes on a, b or borrow_in outside the accepted start edge have no effect.
- Elaboration must fail (generate-time error) if WIDTH % DIGIT != 0 or DIGIT < 1.

Test Plan:
1. WIDTH=16, DIGIT=4: a=0x1234, b=0x0234, bin=0 -> done 4 cycles after the start edge; diff=0x1000, borrow_out=0, overflow=0, zero=0; busy high for exactly 4 cycles.
2. Wrap and borrow: a=0x0000, b=0x0001 -> diff=0xFFFF, borrow_out=1, overflow=0. Then a=0x8000, b=0x0001 -> diff=0x7FFF, borrow_out=0, overflow=1.
3. borrow_in and zero: a=0x0005, b=0x0004, bin=1 -> diff=0x0000, zero=1, borrow_out=0. Also a=0x0000, b=0xFFFF, bin=1 -> diff=0x0000, borrow_out=1, zero=1.
4. Handshake: pulse start with new operands while busy -> ignored, original result delivered. Assert start during the done cycle with a=3, b=5 -> second done exactly N cycles later with diff=0xFFFE, borrow_out=1.
5. Reset mid-operation: assert rst 2 cycles after start -> all outputs 0 immediately and no done. Restart after release -> correct result.
6. Configurations DIGIT=1 (N=16) and DIGIT=16 (N=1): random 1000-vector compare against a - b - bin reference model, including busy/done timing per the latency rule.
